if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage of the single-issue MIPS-style pipeline. Owns the program counter, drives the byte address into the combinational instruction memory (`IM`), and registers the returned word into the IF/ID pipeline register together with PC+4 and a valid bit. Supports stall, branch/jump redirect with bubble insertion, and an optional halt-on-opcode state machine. Sits between `IM` (consumer of `Address`) and the decode stage (consumer of the IF/ID outputs).

## Interface
- `PC_W`, 8, PC/address width in bits; matches the `IM` `Address` width.
- `INSTR_W`, 32, instruction width in bits.
- `RESET_PC`, 8'h00, PC value loaded on reset; must be word-aligned.
- `Clk`  in  1  rising-edge clock; the only clock.
- `Reset`  in  1  synchronous, active-high reset.
- `Stall`  in  1  hazard-unit hold: freezes the PC and IF/ID.
- `Redirect`  in  1  taken branch or jump resolved downstream.
- `RedirectAddr`  in  PC_W  new PC for a redirect; bits [1:0] are ignored (forced 0).
- `InstructionIn`  in  INSTR_W  word returned combinationally by `IM`.
- `Address`  out  PC_W  current PC, driven to `IM.Address`.
- `IF_ID_Instruction`  out  INSTR_W  registered instruction.
- `IF_ID_PCPlus4`  out  PC_W  registered PC+4 of that instruction.
- `IF_ID_Valid`  out  1  IF/ID holds a real instruction (0 = bubble).
- `Halted`  out  1  fetch is stopped on a HALT opcode.
- `FetchCount`  out  16  count of valid instructions delivered into IF/ID.

## Operation
- `Address` = PC register, with no combinational path from any input.
- Per-edge priority: Reset > Redirect > Halted hold > Stall > normal fetch.
- Reset: PC=RESET_PC, IF_ID_Instruction=0, IF_ID_PCPlus4=0, IF_ID_Valid=0, Halted=0, FetchCount=0, state RUN.
- Normal fetch (RUN, no Stall, no Redirect): IF/ID <= {InstructionIn, PC+4, 1}; PC <= PC+4; FetchCount += 1.
- Stall (RUN, no Redirect): PC, IF/ID and FetchCount all hold their values.
- Redirect, in any state and regardless of Stall: PC <= {RedirectAddr[PC_W-1:2], 2'b00}; IF_ID_Valid <= 0 (the wrong-path word is squashed); IF_ID_Instruction <= 0; state <= RUN.
- PC arithmetic is modulo 2^PC_W: PC 8'hFC +4 gives 8'h00 with no error flag.
- FetchCount saturates at 16'hFFFF.
- States are RUN and HALTED.
  - RUN -> HALTED on a normal-fetch edge when InstructionIn[31:26]==6'h3F. The HALT word is not delivered: IF_ID_Valid <= 0, PC holds at the HALT address, FetchCount is unchanged.
  - HALTED -> RUN only on Redirect (an older in-flight branch overrides the speculative halt) or on Reset.
  - In HALTED, Stall has no effect and IF_ID_Valid stays 0.
- `Halted` = (state == HALTED), registered.

## Timing
- Fetch latency: 1 cycle. The word at `Address` in cycle N appears on the IF/ID outputs after edge N.
- The first valid instruction appears one edge after Reset deasserts, with IF_ID_PCPlus4 = RESET_PC+4.
- Redirect asserted in cycle N: `Address` = target in cycle N+1. Exactly one bubble is inserted, and the target instruction is valid after edge N+1.
- Stall is level-sensitive. Each stalled cycle adds one cycle, and no instruction is dropped or duplicated.
- Reset asserted mid-stall, mid-redirect, or in HALTED wins on that same edge.

## Configuration
- `IF_HALT_EN` defined: the HALT detection, the HALTED state, and the `Halted` logic are compiled in as described above.
- `IF_HALT_EN` undefined: opcode 6'h3F is fetched as an ordinary instruction. The state register is removed, and `Halted` is tied to 0.

## Structure
- Package `if_pkg`: PC_W and INSTR_W defaults, the `OP_HALT` = 6'h3F constant, the RUN/HALTED state enum, and the `PC_STEP` = 4 constant.
- One sub-module, `if_id_reg`: the IF/ID register with load, hold, and squash controls. `if_stage` keeps the PC, the state machine, and the counter.

## Test plan
- Reset, then 10 free-running cycles with IM preloaded with words at 0..32 -> `Address` sequence 0,4,8,…; IF_ID_Instruction tracks iM[0], iM[4], …; FetchCount=9 after nine fetches.
- Stall held for 3 cycles while PC=8'h08 -> `Address` stays 8'h08, IF/ID stays at the iM[4] word, FetchCount is unchanged. After release, the iM[8] word is delivered exactly once.
- Redirect with RedirectAddr=8'h1E while PC=8'h0C and Stall=1 -> next `Address`=8'h1C, IF_ID_Valid=0 for one cycle, then the iM[28] word is valid with IF_ID_PCPlus4=8'h20.
- PC forced to 8'hFC via redirect -> the next `Address` is 8'h00 and no error is raised.
- `IF_HALT_EN` defined, word 32'hFC00_0000 at 8'h24 -> Halted=1 after that edge, `Address` stays 8'h24, IF_ID_Valid=0. A later Redirect to 8'h00 clears Halted and fetch resumes.
- Reset asserted while Halted=1 with Redirect=1 on the same edge -> PC=RESET_PC, Halted=0, FetchCount=0, IF_ID_Valid=0.

Source files
------------

// File: rtl/if_pkg.sv
// -----------------------------------------------------------------------------
// if_pkg
//   Shared constants and types for the instruction-fetch stage.
//   - PC_W_DEF / INSTR_W_DEF : default PC and instruction widths
//   - OP_HALT                : primary opcode that stops fetch (when the
//                              IF_HALT_EN build option is enabled)
//   - PC_STEP                : byte distance between sequential instructions
//   - if_state_e             : fetch state machine encoding (RUN / HALTED)
// -----------------------------------------------------------------------------
package if_pkg;

  localparam int PC_W_DEF    = 8;
  localparam int INSTR_W_DEF = 32;
  localparam int OPCODE_W    = 6;
  localparam int CNT_W       = 16;
  localparam int PC_STEP     = 4;

  localparam logic [OPCODE_W-1:0] OP_HALT = 6'h3F;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } if_state_e;

  // True when the primary opcode field selects the HALT instruction.
  function automatic logic is_halt_op(input logic [OPCODE_W-1:0] opcode);
    return opcode == OP_HALT;
  endfunction

endpackage

// File: rtl/if_stage_if_id_reg.sv
// -----------------------------------------------------------------------------
// if_id_reg
//   IF/ID pipeline register with load, hold and squash controls.
//   Ports:
//     clk, reset            : clock and synchronous active-high reset
//     load                  : capture instr_in / pc_plus4_in, mark valid
//     squash                : turn the register into a bubble (valid=0,
//                             instruction=0); wins over load
//     instr_in, pc_plus4_in : payload from the fetch stage
//     instr, pc_plus4, valid: registered payload and valid bit
//   With neither load nor squash the register holds its contents.
// -----------------------------------------------------------------------------
module if_id_reg
  import if_pkg::*;
#(
  parameter int PC_W    = PC_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               squash,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic [PC_W-1:0]    pc_plus4_in,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    pc_plus4,
  output logic               valid
);

  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]    pc_plus4_q, pc_plus4_d;
  logic               valid_q, valid_d;

  always_comb begin
    instr_d    = instr_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    if (squash) begin
      // PC+4 of a bubble is meaningless downstream, so it is left as-is.
      instr_d = '0;
      valid_d = 1'b0;
    end else if (load) begin
      instr_d    = instr_in;
      pc_plus4_d = pc_plus4_in;
      valid_d    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q    <= '0;
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      instr_q    <= instr_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
    end
  end

  assign instr    = instr_q;
  assign pc_plus4 = pc_plus4_q;
  assign valid    = valid_q;

endmodule

// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage
//   Instruction-fetch stage: owns the PC, addresses the combinational
//   instruction memory and registers the returned word into IF/ID.
//
//   Build option: IF_HALT_EN
//     defined   -> opcode OP_HALT stops fetch (RUN -> HALTED) until a
//                  Redirect or Reset; Halted reflects the state register.
//     undefined -> OP_HALT is an ordinary instruction, no state register,
//                  Halted is tied to 0.
//
//   Ports:
//     Clk, Reset        : clock, synchronous active-high reset
//     Stall             : hold PC, IF/ID and FetchCount
//     Redirect          : load PC from RedirectAddr (word aligned), squash IF/ID
//     RedirectAddr      : redirect target; bits [1:0] ignored
//     InstructionIn     : word read from IM at Address
//     Address           : current PC (registered, no input-to-output path)
//     IF_ID_Instruction : registered instruction
//     IF_ID_PCPlus4     : registered PC+4 of that instruction
//     IF_ID_Valid       : IF/ID holds a real instruction (0 = bubble)
//     Halted            : fetch stopped on a HALT opcode (state == HALTED)
//     FetchCount        : saturating count of instructions delivered
//
//   Handshake to decode: IF_ID_Valid is the valid bit and ~Stall acts as the
//   ready bit. A word transfers on an edge where Valid=1 and Stall=0; while
//   Stall=1 the IF/ID payload and Valid are held unchanged, so nothing is
//   dropped or duplicated. Redirect overrides Stall and replaces IF/ID with a
//   bubble.
//
//   Edge priority: Reset > Redirect > HALTED hold > Stall > normal fetch.
// -----------------------------------------------------------------------------
module if_stage
  import if_pkg::*;
#(
  parameter int             PC_W     = PC_W_DEF,
  parameter int             INSTR_W  = INSTR_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Stall,
  input  logic               Redirect,
  input  logic [PC_W-1:0]    RedirectAddr,
  input  logic [INSTR_W-1:0] InstructionIn,
  output logic [PC_W-1:0]    Address,
  output logic [INSTR_W-1:0] IF_ID_Instruction,
  output logic [PC_W-1:0]    IF_ID_PCPlus4,
  output logic               IF_ID_Valid,
  output logic               Halted,
  output logic [CNT_W-1:0]   FetchCount
);

  // Reset value and redirect targets are forced onto a word boundary.
  localparam logic [PC_W-1:0] RESET_PC_ALIGNED = {RESET_PC[PC_W-1:2], 2'b00};

  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] fetch_count_q, fetch_count_d;
  logic [PC_W-1:0]  pc_plus4;
  logic [PC_W-1:0]  redirect_pc;
  logic             ifid_load;
  logic             ifid_squash;
  logic             enter_halt;
  logic             halt_op;
  logic             in_halted;

  // Target low bits are architecturally zero; they are intentionally dropped.
  logic             unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^RedirectAddr[1:0];

  // Wraps modulo 2^PC_W by construction of the PC_W-bit sum.
  assign pc_plus4    = pc_q + PC_W'(PC_STEP);
  assign redirect_pc = {RedirectAddr[PC_W-1:2], 2'b00};

  // ---------------------------------------------------------------------------
  // Optional HALT state machine
  // ---------------------------------------------------------------------------
`ifdef IF_HALT_EN
  if_state_e state_q, state_d;

  // Opcode field is the top OPCODE_W bits of the instruction word.
  assign halt_op   = is_halt_op(InstructionIn[INSTR_W-1 -: OPCODE_W]);
  assign in_halted = (state_q == ST_HALTED);

  always_comb begin
    state_d = state_q;
    if (Redirect) begin
      // An older branch resolving downstream overrides the speculative halt.
      state_d = ST_RUN;
    end else if (enter_halt) begin
      state_d = ST_HALTED;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Halted comes straight off the state flop, so it is a registered output.
  assign Halted = in_halted;
`else
  assign halt_op   = 1'b0;
  assign in_halted = 1'b0;
  assign Halted    = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // PC / counter next-state and IF/ID controls
  // ---------------------------------------------------------------------------
  always_comb begin
    pc_d          = pc_q;
    fetch_count_d = fetch_count_q;
    ifid_load     = 1'b0;
    ifid_squash   = 1'b0;
    enter_halt    = 1'b0;

    if (Redirect) begin
      // The word currently fetched is wrong-path: replace it with a bubble.
      pc_d        = redirect_pc;
      ifid_squash = 1'b1;
    end else if (in_halted) begin
      // Frozen until a redirect; IF/ID already holds a bubble.
      pc_d = pc_q;
    end else if (Stall) begin
      pc_d = pc_q;
    end else if (halt_op) begin
      // HALT is not delivered: PC stays on it and IF/ID becomes a bubble.
      enter_halt  = 1'b1;
      ifid_squash = 1'b1;
    end else begin
      pc_d      = pc_plus4;
      ifid_load = 1'b1;
      if (fetch_count_q != '1) begin
        fetch_count_d = fetch_count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pc_q          <= RESET_PC_ALIGNED;
      fetch_count_q <= '0;
    end else begin
      pc_q          <= pc_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign Address    = pc_q;
  assign FetchCount = fetch_count_q;

  // ---------------------------------------------------------------------------
  // IF/ID pipeline register
  // ---------------------------------------------------------------------------
  if_id_reg #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W)
  ) u_if_id_reg (
    .clk         (Clk),
    .reset       (Reset),
    .load        (ifid_load),
    .squash      (ifid_squash),
    .instr_in    (InstructionIn),
    .pc_plus4_in (pc_plus4),
    .instr       (IF_ID_Instruction),
    .pc_plus4    (IF_ID_PCPlus4),
    .valid       (IF_ID_Valid)
  );

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

  // ---------------------------------------------------------------------------
  // Clock / DUT signals
  // ---------------------------------------------------------------------------
  logic        Clk = 1'b0;
  logic        Reset;
  logic        Stall;
  logic        Redirect;
  logic [7:0]  RedirectAddr;
  logic [31:0] InstructionIn;
  logic [7:0]  Address;
  logic [31:0] IF_ID_Instruction;
  logic [7:0]  IF_ID_PCPlus4;
  logic        IF_ID_Valid;
  logic        Halted;
  logic [15:0] FetchCount;

  always #5 Clk = ~Clk;

`ifdef IF_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  // Instruction memory model: 64 words, read combinationally.
  logic [31:0] im [0:63];
  assign InstructionIn = im[Address[7:2]];

  if_stage #(
    .PC_W     (8),
    .INSTR_W  (32),
    .RESET_PC (8'h00)
  ) dut (
    .Clk               (Clk),
    .Reset             (Reset),
    .Stall             (Stall),
    .Redirect          (Redirect),
    .RedirectAddr      (RedirectAddr),
    .InstructionIn     (InstructionIn),
    .Address           (Address),
    .IF_ID_Instruction (IF_ID_Instruction),
    .IF_ID_PCPlus4     (IF_ID_PCPlus4),
    .IF_ID_Valid       (IF_ID_Valid),
    .Halted            (Halted),
    .FetchCount        (FetchCount)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard and reference state
  // ---------------------------------------------------------------------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [39:0] exp_q[$];      // {instruction, pc_plus4} of each delivery
  logic [31:0] last_instr;
  logic [7:0]  last_pc4;
  logic [7:0]  m_pc;
  logic        m_valid;
  logic        m_halted;
  logic [15:0] m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".addr"},   {24'h0, Address},     {24'h0, m_pc});
    chk({tag, ".valid"},  {31'h0, IF_ID_Valid}, {31'h0, m_valid});
    chk({tag, ".halted"}, {31'h0, Halted},      {31'h0, m_halted});
    chk({tag, ".count"},  {16'h0, FetchCount},  {16'h0, m_cnt});
  endtask

  task automatic do_reset(input logic s, input logic r, input logic [7:0] ra, input string tag);
    Reset = 1'b1; Stall = s; Redirect = r; RedirectAddr = ra;
    @(posedge Clk); #1;
    m_pc = 8'h00; m_valid = 1'b0; m_halted = 1'b0; m_cnt = 16'h0;
    exp_q.delete();
    check_state(tag);
    chk({tag, ".instr"}, IF_ID_Instruction, 32'h0);
    chk({tag, ".pc4"},   {24'h0, IF_ID_PCPlus4}, 32'h0);
    Reset = 1'b0; Stall = 1'b0; Redirect = 1'b0;
  endtask

  // One clock edge with the given controls; the reference model predicts the
  // outcome before the edge and the DUT is checked 1 time unit after it.
  task automatic step(input logic s, input logic r, input logic [7:0] ra, input string tag);
    logic [31:0] word;
    logic [39:0] exp;
    logic        delivered;
    logic        squashed;
    Stall = s; Redirect = r; RedirectAddr = ra;
    word = im[m_pc[7:2]];
    delivered = 1'b0;
    squashed  = 1'b0;
    if (r) begin
      m_pc = {ra[7:2], 2'b00};
      m_valid = 1'b0;
      m_halted = 1'b0;
      squashed = 1'b1;
    end else if (m_halted) begin
      m_valid = 1'b0;
    end else if (s) begin
      m_pc = m_pc;
    end else if (HALT_EN && word[31:26] == 6'h3F) begin
      m_halted = 1'b1;
      m_valid = 1'b0;
    end else begin
      exp_q.push_back({word, m_pc + 8'd4});
      m_pc = m_pc + 8'd4;
      m_valid = 1'b1;
      delivered = 1'b1;
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end
    @(posedge Clk); #1;
    check_state(tag);
    if (delivered) begin
      if (exp_q.size() == 0) begin
        chk({tag, ".sb_empty"}, 32'h1, 32'h0);
      end else begin
        exp = exp_q.pop_front();
        last_instr = exp[39:8];
        last_pc4   = exp[7:0];
        chk({tag, ".instr"}, IF_ID_Instruction, last_instr);
        chk({tag, ".pc4"},   {24'h0, IF_ID_PCPlus4}, {24'h0, last_pc4});
      end
    end else if (squashed) begin
      chk({tag, ".sq_instr"}, IF_ID_Instruction, 32'h0);
    end else if (m_valid) begin
      chk({tag, ".hold_instr"}, IF_ID_Instruction, last_instr);
      chk({tag, ".hold_pc4"},   {24'h0, IF_ID_PCPlus4}, {24'h0, last_pc4});
    end
    Stall = 1'b0; Redirect = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    Reset = 1'b1; Stall = 1'b0; Redirect = 1'b0; RedirectAddr = 8'h00;
    last_instr = 32'h0; last_pc4 = 8'h0;
    for (int i = 0; i < 64; i++) begin
      im[i] = {6'($urandom_range(0, 62)), 26'($urandom)};
    end
    im[9] = 32'hFC00_0000;   // HALT opcode at byte address 8'h24

    // Reset state
    do_reset(1'b0, 1'b0, 8'h00, "reset");

    // Free-running fetch: addresses 0,4,8,... and nine deliveries
    for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 8'h00, "run");
    chk("run9.addr",  {24'h0, Address}, 32'h24);
    chk("run9.count", {16'h0, FetchCount}, 32'd9);
    chk("run9.instr", IF_ID_Instruction, im[8]);

    // Stall for three cycles with PC=8'h08
    step(1'b0, 1'b1, 8'h00, "redir0");
    step(1'b0, 1'b0, 8'h00, "fetch0");
    step(1'b0, 1'b0, 8'h00, "fetch4");
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h00, "stall");
    chk("stall.addr",  {24'h0, Address}, 32'h08);
    chk("stall.instr", IF_ID_Instruction, im[1]);
    step(1'b0, 1'b0, 8'h00, "release");
    chk("release.instr", IF_ID_Instruction, im[2]);

    // Redirect to 8'h1E while stalled at PC=8'h0C
    step(1'b1, 1'b1, 8'h1E, "redir1e");
    chk("redir1e.addr", {24'h0, Address}, 32'h1C);
    step(1'b0, 1'b0, 8'h00, "target");
    chk("target.instr", IF_ID_Instruction, im[7]);
    chk("target.pc4",   {24'h0, IF_ID_PCPlus4}, 32'h20);

    // PC wrap from 8'hFC to 8'h00 (redirect low bits ignored)
    step(1'b0, 1'b1, 8'hFF, "redirfc");
    chk("redirfc.addr", {24'h0, Address}, 32'hFC);
    step(1'b0, 1'b0, 8'h00, "wrap");
    chk("wrap.addr", {24'h0, Address}, 32'h00);
    chk("wrap.pc4",  {24'h0, IF_ID_PCPlus4}, 32'h00);

    // HALT opcode at 8'h24
    step(1'b0, 1'b1, 8'h20, "redir20");
    step(1'b0, 1'b0, 8'h00, "pre_halt");
    step(1'b0, 1'b0, 8'h00, "halt_word");
`ifdef IF_HALT_EN
    chk("halt.halted", {31'h0, Halted}, 32'h1);
    chk("halt.addr",   {24'h0, Address}, 32'h24);
    step(1'b1, 1'b0, 8'h00, "halt_stall");
    step(1'b0, 1'b0, 8'h00, "halt_idle");
    step(1'b0, 1'b1, 8'h00, "halt_redir");
    chk("unhalt.halted", {31'h0, Halted}, 32'h0);
    step(1'b0, 1'b0, 8'h00, "resume");
    chk("resume.instr", IF_ID_Instruction, im[0]);
`else
    chk("nohalt.halted", {31'h0, Halted}, 32'h0);
    chk("nohalt.addr",   {24'h0, Address}, 32'h28);
    chk("nohalt.instr",  IF_ID_Instruction, 32'hFC00_0000);
`endif

    // Reset on the same edge as Redirect and Stall (and HALTED if built in)
    step(1'b0, 1'b1, 8'h24, "redir24");
    step(1'b0, 1'b0, 8'h00, "halt_again");
    do_reset(1'b1, 1'b1, 8'h40, "reset_mid");
    step(1'b0, 1'b0, 8'h00, "first");
    chk("first.pc4", {24'h0, IF_ID_PCPlus4}, 32'h04);
    step(1'b0, 1'b0, 8'h00, "second");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
